// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   XLEN          : datapath width
//   NOP_INSTR     : addi x0,x0,0, placed in IF/ID whenever it holds no instruction
//   fetch_state_t : fetch controller states
//   word_align    : clears the two byte-offset bits of an address
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_holdbuf.sv
// One-entry skid register for a fetch response that arrives while the
// pipeline is stalled.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   load               : capture {load_pc, load_instr}
//   clear              : empty the entry (wins over load)
//   load_pc, load_instr: data to capture
//   valid, pc, instr   : registered contents
module fetch_holdbuf
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  // Entry storage: clear has priority so a redirect always empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= 32'h0000_0000;
      instr <= NOP_INSTR;
    end else if (clear) begin
      valid <= 1'b0;
      pc    <= pc;
      instr <= instr;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else begin
      valid <= valid;
      pc    <= pc;
      instr <= instr;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues single-outstanding requests
// to instruction memory, loads the IF/ID register and redirects on a taken
// branch (squashing the wrong-path fetch).
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   stall                 : hazard stall, IF/ID and PC hold
//   BrTaken, BrTarget     : redirect request from the branch unit
//   imem_req, imem_addr   : fetch request / address (stable until accepted)
//   imem_rdata, imem_valid: fetch response (zero-wait or later)
//   ifid_pc/pc4/instr/valid : IF/ID pipeline register
//   flush                 : combinational, BrTaken outside BOOT
//   misalign              : one-cycle pulse for a redirect to a non-word address
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        BrTaken,
  input  logic [31:0] BrTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        flush,
  output logic        misalign
);

  fetch_state_t state_r;
  logic [31:0]  pc_r;
  logic [31:0]  drop_addr_r;

  logic         hb_load_s;
  logic         hb_clear_s;
  logic         hb_valid_s;
  logic [31:0]  hb_pc_s;
  logic [31:0]  hb_instr_s;

  fetch_holdbuf u_holdbuf (
    .clk        (clk),
    .rst        (rst),
    .load       (hb_load_s),
    .clear      (hb_clear_s),
    .load_pc    (pc_r),
    .load_instr (imem_rdata),
    .valid      (hb_valid_s),
    .pc         (hb_pc_s),
    .instr      (hb_instr_s)
  );

  // Request and address are pure decodes of registered state; in DROP the
  // stale address is re-presented until memory completes it.
  assign imem_req  = (state_r == REQ) || (state_r == DROP);
  assign imem_addr = (state_r == DROP) ? drop_addr_r : pc_r;
  assign flush     = BrTaken && (state_r != BOOT);

  // Hold-buffer control: capture a response that lands during a stall,
  // release it when the stall drops or a redirect kills it.
  always_comb begin
    hb_load_s  = 1'b0;
    hb_clear_s = 1'b0;
    if (state_r == REQ) begin
      hb_load_s = !BrTaken && imem_valid && stall;
    end else if (state_r == HOLD) begin
      hb_clear_s = BrTaken || !stall;
    end else begin
      hb_load_s  = 1'b0;
      hb_clear_s = 1'b0;
    end
  end

  // Fetch controller, PC and IF/ID register. Priority in REQ is
  // redirect > response > stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= BOOT;
      pc_r        <= RESET_PC;
      drop_addr_r <= 32'h0000_0000;
      ifid_pc     <= 32'h0000_0000;
      ifid_pc4    <= 32'h0000_0000;
      ifid_instr  <= NOP_INSTR;
      ifid_valid  <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      misalign <= 1'b0;
      case (state_r)
        BOOT: begin
          state_r <= REQ;
        end
        REQ: begin
          if (BrTaken) begin
            pc_r       <= word_align(BrTarget);
            misalign   <= |BrTarget[1:0];
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
            // A response arriving now completes the request, so no drain needed.
            if (imem_valid) begin
              state_r <= REQ;
            end else begin
              drop_addr_r <= pc_r;
              state_r     <= DROP;
            end
          end else if (imem_valid) begin
            if (!stall) begin
              ifid_pc    <= pc_r;
              ifid_pc4   <= pc_r + 32'd4;
              ifid_instr <= imem_rdata;
              ifid_valid <= 1'b1;
              pc_r       <= pc_r + 32'd4;
            end else begin
              state_r <= HOLD;
            end
          end else if (!stall) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
          end else begin
            state_r <= REQ;
          end
        end
        HOLD: begin
          if (BrTaken) begin
            pc_r       <= word_align(BrTarget);
            misalign   <= |BrTarget[1:0];
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
            state_r    <= REQ;
          end else if (!stall && hb_valid_s) begin
            ifid_pc    <= hb_pc_s;
            ifid_pc4   <= hb_pc_s + 32'd4;
            ifid_instr <= hb_instr_s;
            ifid_valid <= 1'b1;
            pc_r       <= hb_pc_s + 32'd4;
            state_r    <= REQ;
          end else begin
            state_r <= HOLD;
          end
        end
        DROP: begin
          if (BrTaken) begin
            pc_r       <= word_align(BrTarget);
            misalign   <= |BrTarget[1:0];
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
          end else begin
            pc_r <= pc_r;
          end
          // Stale response is discarded; fetch resumes at the current PC.
          if (imem_valid) begin
            state_r <= REQ;
          end else begin
            state_r <= DROP;
          end
        end
        default: begin
          state_r <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the branch-evaluation path.
- Holds the PC and issues single-outstanding requests to instruction memory.
- Loads the IF/ID pipeline register.
- Redirects to the branch target when the downstream branch unit asserts BrTaken, squashing wrong-path fetches and raising flush to later stages.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word placed in IF/ID when invalid (addi x0,x0,0).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard-unit stall; IF/ID and PC hold.
- BrTaken  input  1  branch unit result (already qualified by Branch).
- BrTarget  input  32  redirect target, valid when BrTaken=1.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address, stable while imem_req=1 until accepted.
- imem_rdata  input  32  instruction word, valid when imem_valid=1.
- imem_valid  input  1  response; may be asserted in the same cycle as imem_req (zero-wait) or later.
- ifid_pc  output  32  PC of the instruction in IF/ID.
- ifid_pc4  output  32  ifid_pc+4.
- ifid_instr  output  32  fetched instruction.
- ifid_valid  output  1  IF/ID holds a real instruction.
- flush  output  1  combinational; equals BrTaken; kills the ID/EX wrong-path instruction.
- misalign  output  1  one-cycle registered pulse; BrTaken with BrTarget[1:0]!=0.

Behaviour:
- Reset (async): pc=RESET_PC, state=BOOT, imem_req=0, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc4=0, misalign=0, hold buffer empty.
- Rst asserted mid-request: drop everything; any response arriving after reset release while in BOOT is ignored.
- States: BOOT, REQ, HOLD, DROP.
- BOOT:
  - imem_req=0.
  - Next cycle -> REQ.
  - BrTaken in BOOT is ignored.
- REQ:
  - imem_req=1, imem_addr=pc.
  - Priority: BrTaken > imem_valid > stall.
  - BrTaken:
    - pc<=BrTarget with [1:0] forced to 00; misalign<=|BrTarget[1:0].
    - ifid_valid<=0, ifid_instr<=NOP_INSTR.
    - If imem_valid is high this cycle, discard the response and stay in REQ; else -> DROP, capturing drop_addr<=current pc.
  - imem_valid with stall=0:
    - IF/ID<={pc, pc+4, imem_rdata}, ifid_valid<=1.
    - pc<=pc+4; stay in REQ. Back-to-back fetch gives one instruction per cycle with zero-wait memory.
  - imem_valid with stall=1: buffer {pc, imem_rdata} into the hold register; IF/ID unchanged -> HOLD.
  - No imem_valid: if stall=0, ifid_valid<=0 (bubble); if stall=1, IF/ID holds.
- HOLD:
  - imem_req=0.
  - BrTaken: redirect as above, clear the buffer -> REQ.
  - stall=0: IF/ID<=buffer, ifid_valid<=1, pc<=buffered pc+4 -> REQ.
  - Else: stay in HOLD.
- DROP:
  - imem_req=1, imem_addr=drop_addr (stale request must complete).
  - On imem_valid: discard the response, IF/ID stays invalid -> REQ at the current pc.
  - BrTaken in DROP: pc<=new target, remain in DROP.
  - stall has no effect in DROP.
- flush=BrTaken in every state except BOOT.
- PC arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC -> 32'h0000_0000.
- BrTaken and stall in the same cycle: the redirect wins; IF/ID is invalidated, not held.

Decomposition:
- Shared package riscv_pkg holds:
  - fetch_state_t enum (BOOT, REQ, HOLD, DROP).
  - NOP_INSTR constant.
  - XLEN=32.
- One sub-module is natural: fetch_holdbuf, a one-entry {pc, instr} skid register with load/clear/valid.

Test Plan:
- Reset release, zero-wait memory returning imem_rdata=addr -> ifid_pc sequence 0,4,8,12 on consecutive cycles; ifid_valid=1 from the 3rd cycle after reset deassertion.
- stall=1 for 3 cycles while a response for pc=0x10 arrives -> ifid_pc stays 0x0C, imem_req=0 in HOLD; on release, ifid_pc=0x10 and the next request is 0x14.
- BrTaken=1, BrTarget=0x200 while the memory has a 2-cycle latency and a request is outstanding for 0x18 -> flush=1 that cycle, imem_addr stays 0x18 until imem_valid, that instruction is never in IF/ID, then imem_addr=0x200.
- BrTaken with BrTarget=0x102 -> misalign pulses 1 cycle, next fetch address 0x100.
- pc=0xFFFF_FFFC, normal fetch -> next imem_addr=0x0000_0000.
- rst asserted mid-DROP -> all outputs at reset values in the same cycle; fetch restarts from RESET_PC.
